// File: rtl/irq_vic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_vic_pkg
//  Description : Shared constants for the vectored interrupt controller:
//                configuration-select codes and source trigger-mode values.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_vic_pkg;

    // Configuration write targets (i_cfg_sel)
    localparam logic [1:0] CFG_ENABLE   = 2'd0;
    localparam logic [1:0] CFG_MODE     = 2'd1;
    localparam logic [1:0] CFG_FIQSEL   = 2'd2;
    localparam logic [1:0] CFG_PEND_CLR = 2'd3;

    // Per-source trigger mode bit values
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage : irq_vic_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational lowest-index-first priority encoder.
//  Ports       : req - request vector (N bits)
//                any - at least one request bit set
//                id  - index of the lowest set bit (0 when none set)
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic            any,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the lowest set index is the last to write id.
    always_comb begin
        id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign any = |req;

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_vic.sv
`default_nettype none
// ============================================================================
//  Module      : irq_vic
//  Description : Vectored interrupt controller with per-source enable,
//                level/edge mode and IRQ/FIQ routing. Registered IRQ and FIQ
//                requests with source IDs; each line has an in-service bit
//                that blocks re-assertion until end-of-interrupt.
//  Ports       : clk, rst (sync, active-high), en (core advance enable)
//                i_src        - raw synchronous interrupt sources
//                i_cfg_*      - configuration write port (sel/wdata/we)
//                i_irq_ack/eoi, i_fiq_ack/eoi - handler handshake
//                o_irq_flag/id, o_fiq_flag/id - registered requests
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_vic
    import irq_vic_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_cfg_we,
    input  logic [1:0]         i_cfg_sel,
    input  logic [NUM_SRC-1:0] i_cfg_wdata,
    input  logic               i_irq_ack,
    input  logic               i_irq_eoi,
    input  logic               i_fiq_ack,
    input  logic               i_fiq_eoi,
    output logic               o_irq_flag,
    output logic [ID_W-1:0]    o_irq_id,
    output logic               o_fiq_flag,
    output logic [ID_W-1:0]    o_fiq_id
);

    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_fiqsel;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_src_q;
    logic               r_irq_is;
    logic               r_fiq_is;

    logic [NUM_SRC-1:0] w_irq_req;
    logic [NUM_SRC-1:0] w_fiq_req;
    logic               w_irq_any;
    logic               w_fiq_any;
    logic [ID_W-1:0]    w_irq_win;
    logic [ID_W-1:0]    w_fiq_win;
    logic               w_irq_is_eoi;
    logic               w_fiq_is_eoi;
    logic               w_irq_take;
    logic               w_fiq_take;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic [NUM_SRC-1:0] w_pend_clr;
    logic [NUM_SRC-1:0] w_pend_edge;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic               w_mode_wr;

    // ------------------------------------------------------------------
    // Request vectors and priority resolution
    // ------------------------------------------------------------------
    assign w_irq_req = r_pend & r_enable & ~r_fiqsel;
    assign w_fiq_req = r_pend & r_enable &  r_fiqsel;

    irq_prio_enc #(.N(NUM_SRC)) u_irq_enc (
        .req (w_irq_req),
        .any (w_irq_any),
        .id  (w_irq_win)
    );

    irq_prio_enc #(.N(NUM_SRC)) u_fiq_enc (
        .req (w_fiq_req),
        .any (w_fiq_any),
        .id  (w_fiq_win)
    );

    // ------------------------------------------------------------------
    // Handshake: EOI is applied before ack, so an ack in the same cycle as
    // an EOI is judged against the already-cleared in-service bit.
    // ------------------------------------------------------------------
    assign w_irq_is_eoi = r_irq_is & ~(en & i_irq_eoi);
    assign w_fiq_is_eoi = r_fiq_is & ~(en & i_fiq_eoi);
    assign w_irq_take   = en & i_irq_ack & o_irq_flag & ~w_irq_is_eoi;
    assign w_fiq_take   = en & i_fiq_ack & o_fiq_flag & ~w_fiq_is_eoi;

    always_comb begin
        w_ack_clr = '0;
        if (w_irq_take) w_ack_clr[o_irq_id] = 1'b1;
        if (w_fiq_take) w_ack_clr[o_fiq_id] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Pending next-state. Edge sources: a new rising edge beats any clear.
    // Level sources simply follow the raw input; clears do not touch them.
    // A MODE write flushes everything since old pend bits mean nothing
    // under the new trigger interpretation.
    // ------------------------------------------------------------------
    assign w_mode_wr   = i_cfg_we && (i_cfg_sel == CFG_MODE);
    assign w_pend_clr  = (i_cfg_we && (i_cfg_sel == CFG_PEND_CLR)) ? i_cfg_wdata : '0;
    assign w_pend_edge = (i_src & ~r_src_q) | (r_pend & ~(w_ack_clr | w_pend_clr));
    assign w_pend_nxt  = w_mode_wr ? '0
                       : ((r_mode & w_pend_edge) | (~r_mode & i_src));

    // ------------------------------------------------------------------
    // Source sampling, pending and configuration (independent of en)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q  <= '0;
            r_pend   <= '0;
            r_enable <= '0;
            r_mode   <= {NUM_SRC{MODE_LEVEL}};
            r_fiqsel <= '0;
        end else begin
            r_src_q <= i_src;
            r_pend  <= w_pend_nxt;
            if (i_cfg_we) begin
                case (i_cfg_sel)
                    CFG_ENABLE: r_enable <= i_cfg_wdata;
                    CFG_MODE:   r_mode   <= i_cfg_wdata;
                    CFG_FIQSEL: r_fiqsel <= i_cfg_wdata;
                    default:    ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Flags, IDs and in-service bits (advance only while en is high)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_irq_flag <= 1'b0;
            o_irq_id   <= '0;
            o_fiq_flag <= 1'b0;
            o_fiq_id   <= '0;
            r_irq_is   <= 1'b0;
            r_fiq_is   <= 1'b0;
        end else if (en) begin
            o_irq_flag <= w_irq_any & ~r_irq_is;
            o_fiq_flag <= w_fiq_any & ~r_fiq_is;
            if (w_irq_any) o_irq_id <= w_irq_win;
            if (w_fiq_any) o_fiq_id <= w_fiq_win;
            r_irq_is   <= w_irq_is_eoi | w_irq_take;
            r_fiq_is   <= w_fiq_is_eoi | w_fiq_take;
        end
    end

endmodule : irq_vic
`default_nettype wire

// File: tb/tb_irq_vic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_vic
//  Description : Scoreboard bench for irq_vic. A driver applies directed and
//                random stimulus, advances a behavioural model of the
//                controller and queues the expected outputs; a monitor on
//                the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_vic;

    localparam int NS = 8;

    typedef struct {
        logic       irq_flag;
        logic [2:0] irq_id;
        logic       fiq_flag;
        logic [2:0] fiq_id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [NS-1:0] src = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = 2'd0;
    logic [NS-1:0] cfg_wdata = '0;
    logic          irq_ack = 1'b0, irq_eoi = 1'b0, fiq_ack = 1'b0, fiq_eoi = 1'b0;
    logic          irq_flag, fiq_flag;
    logic [2:0]    irq_id, fiq_id;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    irq_vic #(.NUM_SRC(NS)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .i_src       (src),
        .i_cfg_we    (cfg_we),
        .i_cfg_sel   (cfg_sel),
        .i_cfg_wdata (cfg_wdata),
        .i_irq_ack   (irq_ack),
        .i_irq_eoi   (irq_eoi),
        .i_fiq_ack   (fiq_ack),
        .i_fiq_eoi   (fiq_eoi),
        .o_irq_flag  (irq_flag),
        .o_irq_id    (irq_id),
        .o_fiq_flag  (fiq_flag),
        .o_fiq_id    (fiq_id)
    );

    // ------------------------------------------------------------------
    // Reference model state: per-source bit arrays plus per-line handler
    // state, advanced one clock edge at a time.
    // ------------------------------------------------------------------
    bit m_enable[NS], m_edge[NS], m_fiq[NS], m_pend[NS], m_prev[NS];
    bit m_irq_flag, m_fiq_flag, m_irq_busy, m_fiq_busy;
    int m_irq_id, m_fiq_id;

    function automatic int lowest(input bit v[NS]);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        bit irq_v[NS], fiq_v[NS], np[NS];
        int irq_w, fiq_w, irq_ack_id, fiq_ack_id;
        bit irq_busy_n, fiq_busy_n;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_enable[i] = 0; m_edge[i] = 0; m_fiq[i] = 0;
                m_pend[i] = 0; m_prev[i] = 0;
            end
            m_irq_flag = 0; m_fiq_flag = 0; m_irq_busy = 0; m_fiq_busy = 0;
            m_irq_id = 0; m_fiq_id = 0;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            irq_v[i] = m_pend[i] && m_enable[i] && !m_fiq[i];
            fiq_v[i] = m_pend[i] && m_enable[i] &&  m_fiq[i];
        end
        irq_w = lowest(irq_v);
        fiq_w = lowest(fiq_v);
        irq_ack_id = -1;
        fiq_ack_id = -1;
        irq_busy_n = m_irq_busy;
        fiq_busy_n = m_fiq_busy;
        if (en) begin
            // handler bookkeeping: end-of-interrupt first, then entry
            if (irq_eoi) irq_busy_n = 0;
            if (irq_ack && m_irq_flag && !irq_busy_n) begin
                irq_busy_n = 1; irq_ack_id = m_irq_id;
            end
            if (fiq_eoi) fiq_busy_n = 0;
            if (fiq_ack && m_fiq_flag && !fiq_busy_n) begin
                fiq_busy_n = 1; fiq_ack_id = m_fiq_id;
            end
            m_irq_flag = (irq_w >= 0) && !m_irq_busy;
            m_fiq_flag = (fiq_w >= 0) && !m_fiq_busy;
            if (irq_w >= 0) m_irq_id = irq_w;
            if (fiq_w >= 0) m_fiq_id = fiq_w;
        end
        for (int i = 0; i < NS; i++) begin
            if (!m_edge[i]) np[i] = src[i];
            else if (src[i] && !m_prev[i]) np[i] = 1;
            else if (i == irq_ack_id || i == fiq_ack_id) np[i] = 0;
            else if (cfg_we && cfg_sel == 2'd3 && cfg_wdata[i]) np[i] = 0;
            else np[i] = m_pend[i];
        end
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = (cfg_we && cfg_sel == 2'd1) ? 1'b0 : np[i];
            m_prev[i] = src[i];
            if (cfg_we && cfg_sel == 2'd0) m_enable[i] = cfg_wdata[i];
            if (cfg_we && cfg_sel == 2'd1) m_edge[i]   = cfg_wdata[i];
            if (cfg_we && cfg_sel == 2'd2) m_fiq[i]    = cfg_wdata[i];
        end
        m_irq_busy = irq_busy_n;
        m_fiq_busy = fiq_busy_n;
    endtask

    // One clock: predict, queue the expectation, let the edge happen.
    task automatic tick();
        exp_t e;
        model_step();
        e.irq_flag = m_irq_flag;
        e.irq_id   = 3'(m_irq_id);
        e.fiq_flag = m_fiq_flag;
        e.fiq_id   = 3'(m_fiq_id);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [NS-1:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_irq_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_irq_eoi();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    // Directed check against a hand-derived constant.
    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: outputs are registered and presented every cycle.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (irq_flag !== e.irq_flag || irq_id !== e.irq_id ||
                fiq_flag !== e.fiq_flag || fiq_id !== e.fiq_id) begin
                miscompares++;
                $display("FAIL outputs@%0t: got irq=%b/%0d fiq=%b/%0d, required irq=%b/%0d fiq=%b/%0d",
                         $time, irq_flag, irq_id, fiq_flag, fiq_id,
                         e.irq_flag, e.irq_id, e.fiq_flag, e.fiq_id);
            end
        end
    end

    initial begin
        // Reset and defaults: everything disabled
        rst = 1'b1;
        idle(2);
        chk("reset_irq_flag", int'(irq_flag), 0);
        chk("reset_fiq_flag", int'(fiq_flag), 0);
        rst = 1'b0;
        src = 8'hFF;
        idle(3);
        chk("disabled_irq_flag", int'(irq_flag), 0);
        chk("disabled_fiq_flag", int'(fiq_flag), 0);
        src = 8'h00;
        idle(2);

        // Level IRQ on source 3
        cfg(2'd0, 8'h08);
        src = 8'h08;
        idle(2);
        chk("level_flag", int'(irq_flag), 1);
        chk("level_id", int'(irq_id), 3);
        pulse_irq_ack();
        tick();
        chk("level_ack_drop", int'(irq_flag), 0);
        src = 8'h00;
        idle(2);
        pulse_irq_eoi();
        idle(2);
        chk("level_after_eoi", int'(irq_flag), 0);

        // Edge priority: sources 5 and 2 together
        cfg(2'd1, 8'hFF);
        cfg(2'd0, 8'hFF);
        src = 8'h24; tick();
        src = 8'h00; tick();
        chk("edge_first_id", int'(irq_id), 2);
        chk("edge_first_flag", int'(irq_flag), 1);
        pulse_irq_ack();
        tick();
        chk("edge_ack_drop", int'(irq_flag), 0);
        pulse_irq_eoi();
        tick();
        chk("edge_second_flag", int'(irq_flag), 1);
        chk("edge_second_id", int'(irq_id), 5);
        pulse_irq_ack();
        pulse_irq_eoi();
        idle(2);
        chk("edge_all_done", int'(irq_flag), 0);

        // FIQ routing: source 0 to FIQ, source 1 stays IRQ (level)
        cfg(2'd1, 8'h00);
        cfg(2'd2, 8'h01);
        src = 8'h03;
        idle(2);
        chk("route_fiq_flag", int'(fiq_flag), 1);
        chk("route_fiq_id", int'(fiq_id), 0);
        chk("route_irq_flag", int'(irq_flag), 1);
        chk("route_irq_id", int'(irq_id), 1);
        fiq_ack = 1'b1; tick(); fiq_ack = 1'b0;
        tick();
        chk("fiq_ack_drop", int'(fiq_flag), 0);
        chk("fiq_ack_irq_kept", int'(irq_flag), 1);
        src = 8'h00; tick();
        fiq_eoi = 1'b1; tick(); fiq_eoi = 1'b0;
        idle(2);
        cfg(2'd2, 8'h00);

        // en stall with edge source 4
        cfg(2'd1, 8'hFF);
        en = 1'b0;
        src = 8'h10; tick();
        src = 8'h00; tick();
        pulse_irq_ack();
        idle(2);
        chk("stall_flag", int'(irq_flag), 0);
        en = 1'b1;
        tick();
        chk("unstall_flag", int'(irq_flag), 1);
        chk("unstall_id", int'(irq_id), 4);
        pulse_irq_ack();
        tick();
        pulse_irq_eoi();
        idle(2);

        // Collision: new edge on 6 coincides with ack of 6
        src = 8'h40; tick();
        src = 8'h00; tick();
        chk("coll_flag", int'(irq_flag), 1);
        chk("coll_id", int'(irq_id), 6);
        src = 8'h40; irq_ack = 1'b1; tick();
        src = 8'h00; irq_ack = 1'b0; tick();
        chk("coll_held_off", int'(irq_flag), 0);
        pulse_irq_eoi();
        tick();
        chk("coll_reassert", int'(irq_flag), 1);
        chk("coll_reassert_id", int'(irq_id), 6);
        cfg(2'd3, 8'h40);
        tick();
        chk("pend_clr_flag", int'(irq_flag), 0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 7) != 0);
            src       = NS'($urandom & $urandom & $urandom);
            cfg_we    = ($urandom_range(0, 11) == 0);
            cfg_sel   = 2'($urandom_range(0, 3));
            cfg_wdata = NS'($urandom);
            irq_ack   = ($urandom_range(0, 3) == 0);
            irq_eoi   = ($urandom_range(0, 4) == 0);
            fiq_ack   = ($urandom_range(0, 3) == 0);
            fiq_eoi   = ($urandom_range(0, 4) == 0);
            tick();
        end
        rst = 1'b0; en = 1'b1; cfg_we = 1'b0;
        irq_ack = 1'b0; irq_eoi = 1'b0; fiq_ack = 1'b0; fiq_eoi = 1'b0;

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_irq_vic
`default_nettype wire
